// File: rtl/alu_pkg.sv
// Shared encodings, FSM state type and lane-geometry helpers for the vector divide/modulo unit.
// Byte slice k covers bits [8k+7:8k] of an LSB-indexed 64-bit word (slice 7 holds lane 0).
package alu_pkg;

  localparam logic [5:0] OPC_VEC = 6'b101010;
  localparam logic [5:0] FN_VDIV = 6'b001110;
  localparam logic [5:0] FN_VMOD = 6'b001111;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [6:0] lane_width(input logic [1:0] ww);
    case (ww)
      WW_8:    return 7'd8;
      WW_16:   return 7'd16;
      WW_32:   return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

  // Byte slices that hold the least significant byte of their lane.
  function automatic logic [7:0] lane_low(input logic [1:0] ww);
    case (ww)
      WW_8:    return 8'b1111_1111;
      WW_16:   return 8'b0101_0101;
      WW_32:   return 8'b0001_0001;
      default: return 8'b0000_0001;
    endcase
  endfunction

  // Byte slices that hold the most significant byte of their lane.
  function automatic logic [7:0] lane_top(input logic [1:0] ww);
    case (ww)
      WW_8:    return 8'b1111_1111;
      WW_16:   return 8'b1010_1010;
      WW_32:   return 8'b1000_1000;
      default: return 8'b1000_0000;
    endcase
  endfunction

  // Per byte slice: 1 when the whole lane containing it is zero.
  function automatic logic [7:0] lane_zero(input logic [63:0] val, input logic [1:0] ww);
    logic [7:0] lo;
    logic [7:0] tp;
    logic [7:0] acc_v;
    logic [7:0] res;
    logic       acc;
    lo    = lane_low(ww);
    tp    = lane_top(ww);
    acc   = 1'b1;
    acc_v = '0;
    res   = '0;
    for (int k = 0; k < 8; k++) begin
      acc      = (lo[k] ? 1'b1 : acc) & (val[8*k +: 8] == 8'd0);
      acc_v[k] = acc;
    end
    acc = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (tp[k]) acc = acc_v[k];
      res[k] = acc;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_div_seg_step.sv
// One restoring-division iteration across all lanes; eight byte slices whose shift and
// borrow links are cut at lane boundaries selected by i_ww.
module alu_div_seg_step
  import alu_pkg::*;
(
  input  logic [63:0] i_rem,
  input  logic [63:0] i_dvd,
  input  logic [63:0] i_div,
  input  logic [63:0] i_q,
  input  logic [1:0]  i_ww,
  output logic [63:0] o_rem,
  output logic [63:0] o_dvd,
  output logic [63:0] o_q
);

  logic [7:0]  w_low;
  logic [7:0]  w_top;
  logic [63:0] w_shift;
  logic [63:0] w_diff;
  logic [8:0]  w_sub;
  logic [7:0]  w_bout;
  logic [7:0]  w_ge;
  logic        w_msb;
  logic        w_brw;
  logic        w_geb;

  always_comb begin
    w_low   = lane_low(i_ww);
    w_top   = lane_top(i_ww);
    w_shift = {i_rem[62:0], 1'b0};
    w_diff  = '0;
    w_sub   = '0;
    w_bout  = '0;
    w_ge    = '0;
    w_msb   = 1'b0;
    w_brw   = 1'b0;
    w_geb   = 1'b0;
    o_dvd   = {i_dvd[62:0], 1'b0};
    o_q     = {i_q[62:0], 1'b0};
    o_rem   = '0;

    // Dividend lane MSB feeds the remainder's lane LSB.
    for (int k = 7; k >= 0; k--) begin
      if (w_top[k]) w_msb = i_dvd[8*k+7];
      if (w_low[k]) w_shift[8*k] = w_msb;
    end

    for (int k = 0; k < 8; k++) begin
      w_sub = {1'b0, w_shift[8*k +: 8]} - {1'b0, i_div[8*k +: 8]}
            - {8'd0, (w_low[k] ? 1'b0 : w_brw)};
      w_diff[8*k +: 8] = w_sub[7:0];
      w_brw            = w_sub[8];
      w_bout[k]        = w_sub[8];
    end

    // The bit shifted out of the lane top is the (W+1)-th remainder bit.
    for (int k = 7; k >= 0; k--) begin
      if (w_top[k]) w_geb = i_rem[8*k+7] | ~w_bout[k];
      w_ge[k] = w_geb;
    end

    for (int k = 0; k < 8; k++) begin
      o_rem[8*k +: 8] = w_ge[k] ? w_diff[8*k +: 8] : w_shift[8*k +: 8];
      if (w_low[k]) o_q[8*k] = w_ge[k];
    end
  end

endmodule

// File: rtl/alu_vdivmod_unit.sv
// Multi-cycle lane-segmented unsigned VDIV/VMOD responder with valid/ready on both sides.
// Bit 0 of every port is the MSB; internally words are handled LSB-indexed.
module alu_vdivmod_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter bit          DIV0_ONES = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:XLEN-1] rA_64bit_val,
  input  logic [0:XLEN-1] rB_64bit_val,
  input  logic [0:5]      Op_code,
  input  logic [0:5]      R_ins,
  input  logic [0:1]      WW,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:XLEN-1] ALU_out,
  output logic            out_err
);

  state_e      r_state, w_state_nxt;
  logic [6:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_rem, w_rem_nxt;
  logic [63:0] r_dvd, w_dvd_nxt;
  logic [63:0] r_div, w_div_nxt;
  logic [63:0] r_q, w_q_nxt;
  logic [63:0] r_out, w_out_nxt;
  logic [1:0]  r_ww, w_ww_nxt;
  logic        r_mod, w_mod_nxt;
  logic        r_err, w_err_nxt;

  logic [63:0] w_rem_step;
  logic [63:0] w_dvd_step;
  logic [63:0] w_q_step;
  logic [63:0] w_q_fin;
  logic [7:0]  w_zero;
  logic        w_legal;

  alu_div_seg_step u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_div (r_div),
    .i_q   (r_q),
    .i_ww  (r_ww),
    .o_rem (w_rem_step),
    .o_dvd (w_dvd_step),
    .o_q   (w_q_step)
  );

  // The restoring loop yields all-ones for x/0; clear those lanes when zero is wanted.
  always_comb begin
    w_zero  = lane_zero(r_div, r_ww);
    w_q_fin = w_q_step;
    for (int k = 0; k < 8; k++) begin
      if (w_zero[k] && !DIV0_ONES) w_q_fin[8*k +: 8] = 8'd0;
    end
  end

  assign w_legal = (Op_code == OPC_VEC) && ((R_ins == FN_VDIV) || (R_ins == FN_VMOD));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_dvd_nxt   = r_dvd;
    w_div_nxt   = r_div;
    w_q_nxt     = r_q;
    w_out_nxt   = r_out;
    w_ww_nxt    = r_ww;
    w_mod_nxt   = r_mod;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (w_legal) begin
            w_dvd_nxt   = rA_64bit_val;
            w_div_nxt   = rB_64bit_val;
            w_ww_nxt    = WW;
            w_mod_nxt   = (R_ins == FN_VMOD);
            w_cnt_nxt   = lane_width(WW) - 7'd1;
            w_rem_nxt   = '0;
            w_q_nxt     = '0;
            w_err_nxt   = 1'b0;
            w_state_nxt = StBusy;
          end else begin
            w_out_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = StDone;
          end
        end
      end
      StBusy: begin
        w_rem_nxt = w_rem_step;
        w_dvd_nxt = w_dvd_step;
        w_q_nxt   = w_q_step;
        if (r_cnt == 7'd0) begin
          w_out_nxt   = r_mod ? w_rem_step : w_q_fin;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt - 7'd1;
        end
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_out   <= '0;
      r_ww    <= '0;
      r_mod   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_dvd_nxt;
      r_div   <= w_div_nxt;
      r_q     <= w_q_nxt;
      r_out   <= w_out_nxt;
      r_ww    <= w_ww_nxt;
      r_mod   <= w_mod_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign ALU_out   = r_out;
  assign out_err   = r_err;

endmodule

// File: tb/tb_alu_vdivmod_unit.sv
// Self-checking bench for alu_vdivmod_unit: directed cases plus randomized ops checked
// against a per-lane arithmetic reference model.
module tb_alu_vdivmod_unit;

  localparam bit DIV0_ONES = 1'b1;
  localparam logic [5:0] OPC = 6'b101010;
  localparam logic [5:0] FDIV = 6'b001110;
  localparam logic [5:0] FMOD = 6'b001111;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:5]  Op_code;
  logic [0:5]  R_ins;
  logic [0:1]  WW;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] ALU_out;
  logic        out_err;

  int n_tests;
  int n_fail;

  alu_vdivmod_unit #(
    .XLEN      (64),
    .DIV0_ONES (DIV0_ONES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .Op_code      (Op_code),
    .R_ins        (R_ins),
    .WW           (WW),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ALU_out      (ALU_out),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: split into W-bit lanes, apply plain / and %, repack.
  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input bit is_mod, input logic [1:0] ww);
    int unsigned w;
    longint unsigned mask, la, lb, lr, res;
    w    = 8 << ww;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res  = 0;
    for (int i = 0; i < 64 / int'(w); i++) begin
      la = (a >> (i * w)) & mask;
      lb = (b >> (i * w)) & mask;
      if (lb == 0) lr = is_mod ? la : (DIV0_ONES ? mask : 64'd0);
      else         lr = is_mod ? la % lb : la / lb;
      res |= lr << (i * w);
    end
    return res;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [1:0] ww,
                       output logic [63:0] res, output logic err, output int lat);
    check_eq("in_ready_before_accept", in_ready, 1);
    rA_64bit_val = a;
    rB_64bit_val = b;
    Op_code      = opc;
    R_ins        = fn;
    WW           = ww;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    // Scramble operands after accept; the unit must ignore them.
    rA_64bit_val = {$urandom, $urandom};
    rB_64bit_val = {$urandom, $urandom};
    WW           = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("out_valid_within_bound", out_valid, 1);
    res = ALU_out;
    err = out_err;
  endtask

  task automatic release_out(input int hold);
    logic [63:0] v;
    logic        e;
    v = ALU_out;
    e = out_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_alu_out", ALU_out, v);
      check_eq("hold_out_err", out_err, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("idle_after_handshake", in_ready, 1);
    check_eq("no_valid_after_handshake", out_valid, 0);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] opc, input logic [5:0] fn, input logic [1:0] ww,
                       input bit use_const, input logic [63:0] exp_const, input int hold);
    logic [63:0] res, exp;
    logic        err;
    int          lat;
    bit          legal;
    legal = (opc == OPC) && ((fn == FDIV) || (fn == FMOD));
    exp   = legal ? ref_op(a, b, fn == FMOD, ww) : 64'd0;
    issue(a, b, opc, fn, ww, res, err, lat);
    check_eq({tag, "_result"}, res, exp);
    if (use_const) check_eq({tag, "_const"}, res, exp_const);
    check_eq({tag, "_err"}, err, !legal);
    check_eq({tag, "_latency"}, lat, legal ? (8 << ww) + 1 : 1);
    release_out(hold);
  endtask

  initial begin
    logic [63:0] a, b, m;
    logic [5:0]  fn, opc;
    logic [1:0]  ww;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    rA_64bit_val = '0;
    rB_64bit_val = '0;
    Op_code      = '0;
    R_ins        = '0;
    WW           = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_alu_out", ALU_out, 0);
    check_eq("reset_out_err", out_err, 0);

    do_op("w64_div", 64'd102, 64'd10, OPC, FDIV, 2'b11, 1, 64'd10, 0);
    do_op("w64_mod", 64'd102, 64'd10, OPC, FMOD, 2'b11, 1, 64'd2, 0);
    do_op("w8_div", 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, OPC, FDIV, 2'b00,
          1, 64'h0F000F00_03000300, 0);
    do_op("w32_div0", 64'h00000007_00000009, 64'h00000000_00000002, OPC, FDIV, 2'b10,
          1, 64'hFFFFFFFF_00000004, 0);
    do_op("w32_mod0", 64'h00000007_00000009, 64'h00000000_00000002, OPC, FMOD, 2'b10,
          1, 64'h00000007_00000001, 0);
    do_op("illegal_fn", 64'd55, 64'd5, OPC, 6'b000110, 2'b00, 1, 64'd0, 0);
    do_op("legal_after_err", 64'h00640064_00640064, 64'h00070007_00070007, OPC, FDIV, 2'b01,
          1, 64'h000E000E_000E000E, 0);
    do_op("illegal_opc", 64'd9, 64'd3, 6'b000001, FDIV, 2'b11, 1, 64'd0, 0);
    do_op("backpressure", 64'hDEADBEEF_CAFEF00D, 64'h00000123_00000045, OPC, FMOD, 2'b10,
          0, 64'd0, 5);
    do_op("back_to_back", 64'h12345678_9ABCDEF0, 64'h00000000_00001234, OPC, FDIV, 2'b11,
          0, 64'd0, 0);

    // Reset in the third BUSY cycle discards the op.
    check_eq("pre_rst_alu_out_nonzero", (ALU_out != 0), 1);
    rA_64bit_val = 64'hFFFF_FFFF_FFFF_FFFF;
    rB_64bit_val = 64'd3;
    Op_code      = OPC;
    R_ins        = FDIV;
    WW           = 2'b11;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_alu_out", ALU_out, 0);
    do_op("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, OPC, FDIV, 2'b11,
          1, 64'h5555_5555_5555_5555, 0);

    for (int i = 0; i < 30; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ww = 2'($urandom);
      // Narrow the divisor per byte so quotients are interesting; sometimes zero lanes.
      for (int k = 0; k < 8; k++) begin
        m = 64'hFF >> $urandom_range(0, 8);
        b[8*k +: 8] = b[8*k +: 8] & m[7:0];
      end
      if ($urandom_range(0, 3) == 0) b = b & {$urandom, $urandom};
      fn  = $urandom_range(0, 1) ? FMOD : FDIV;
      opc = OPC;
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      do_op("rand", a, b, opc, fn, ww, 0, 64'd0, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
